// File: rtl/ifd_pkg.sv
// Shared types and constants for the 4-bit computer's instruction fetch/decode stage.
// Optional HLT support is controlled by IFD_HALT_EN (see instr_fetch_decode).
package ifd_pkg;

    localparam int IFD_DEPTH = 16;
    localparam int IFD_IW    = 8;
    localparam int IFD_AW    = 4;

    typedef enum logic [3:0] {
        OP_NOP = 4'h0,
        OP_LDA = 4'h1,
        OP_ADD = 4'h2,
        OP_SUB = 4'h3,
        OP_OUT = 4'h4,
        OP_JMP = 4'h5,
        OP_HLT = 4'hF
    } opcode_t;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        DECODE = 3'd2,
        EXEC   = 3'd3,
        HALTED = 3'd4
    } state_t;

    localparam logic [1:0] ACC_LOAD = 2'b00;
    localparam logic [1:0] ACC_ADD  = 2'b01;
    localparam logic [1:0] ACC_SUB  = 2'b10;

    function automatic logic [3:0] opcode_of(input logic [IFD_IW-1:0] instr);
        return instr[IFD_IW-1:IFD_IW-4];
    endfunction

    function automatic logic [3:0] operand_of(input logic [IFD_IW-1:0] instr);
        return instr[3:0];
    endfunction

endpackage

// File: rtl/ifd_prog_mem.sv
// 16x8 program RAM: synchronous write, registered read port with read-before-write.
// The read register doubles as the instruction register, so it alone is reset.
module ifd_prog_mem
    import ifd_pkg::*;
#(
    parameter int DEPTH = IFD_DEPTH,
    parameter int IW    = IFD_IW,
    parameter int AW    = IFD_AW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [IW-1:0] wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [IW-1:0] rdata
);

    // Contents survive rst; power-up value is all NOPs.
    logic [IW-1:0] mem [DEPTH] = '{default: '0};

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Non-blocking read of mem returns the pre-write word on a same-address collision.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/instr_fetch_decode.sv
// Fetch/decode stage: one instruction per cp rising edge, decoded into single-clk control pulses.
// Define IFD_HALT_EN to make opcode F a HLT that parks the FSM until rst.
module instr_fetch_decode
    import ifd_pkg::*;
#(
    parameter int DEPTH = IFD_DEPTH,
    parameter int IW    = IFD_IW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cp,
    input  logic [3:0]    pc_addr,
    input  logic          prog_we,
    input  logic [3:0]    prog_addr,
    input  logic [IW-1:0] prog_data,
    output logic          progC,
    output logic [3:0]    progP,
    output logic          acc_we,
    output logic [1:0]    acc_op,
    output logic [3:0]    operand,
    output logic          out_we,
    output logic [IW-1:0] ir,
    output logic          halted,
    output state_t        fsm_state
);

    state_t     state;
    state_t     next_state;
    logic       cp_q;
    logic       cp_rise;
    logic [3:0] op_q;
    logic       fetch_en;

    assign cp_rise   = cp & ~cp_q;
    assign fetch_en  = (state == FETCH);
    assign fsm_state = state;

    ifd_prog_mem #(
        .DEPTH (DEPTH),
        .IW    (IW),
        .AW    (4)
    ) u_mem (
        .clk   (clk),
        .rst   (rst),
        .we    (prog_we),
        .waddr (prog_addr),
        .wdata (prog_data),
        .re    (fetch_en),
        .raddr (pc_addr),
        .rdata (ir)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cp_q <= 1'b0;
        end else begin
            cp_q <= cp;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:   if (cp_rise) next_state = FETCH;
            FETCH:  next_state = DECODE;
            DECODE: next_state = EXEC;
`ifdef IFD_HALT_EN
            EXEC:   next_state = (op_q == OP_HLT) ? HALTED : IDLE;
            HALTED: next_state = HALTED;
`else
            EXEC:   next_state = IDLE;
`endif
            default: next_state = IDLE;
        endcase
    end

    // Decoded controls are captured in DECODE and hold until the next DECODE,
    // so operand/acc_op/progP are stable across the EXEC pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q    <= 4'h0;
            operand <= 4'h0;
            acc_op  <= ACC_LOAD;
            progP   <= 4'h0;
        end else if (state == DECODE) begin
            op_q    <= opcode_of(ir);
            operand <= operand_of(ir);
            case (opcode_of(ir))
                OP_ADD:  acc_op <= ACC_ADD;
                OP_SUB:  acc_op <= ACC_SUB;
                default: acc_op <= ACC_LOAD;
            endcase
            if (opcode_of(ir) == OP_JMP) begin
                progP <= operand_of(ir);
            end
        end
    end

    // progC is the valid strobe for progP: the PC may sample progP only in the clk
    // where progC=1; there is no ready back-pressure, the PC gates it with its flag.
    always_comb begin
        acc_we = 1'b0;
        out_we = 1'b0;
        progC  = 1'b0;
        if (state == EXEC) begin
            case (op_q)
                OP_LDA, OP_ADD, OP_SUB: acc_we = 1'b1;
                OP_OUT:                 out_we = 1'b1;
                OP_JMP:                 progC  = 1'b1;
                default: ;
            endcase
        end
`ifdef IFD_HALT_EN
        halted = (state == HALTED);
`else
        halted = 1'b0;
`endif
    end

endmodule

// File: tb/tb_instr_fetch_decode.sv
// Directed bench for instr_fetch_decode; HLT checks follow IFD_HALT_EN.
module tb_instr_fetch_decode;
    import ifd_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       cp;
    logic [3:0] pc_addr;
    logic       prog_we;
    logic [3:0] prog_addr;
    logic [7:0] prog_data;
    logic       progC;
    logic [3:0] progP;
    logic       acc_we;
    logic [1:0] acc_op;
    logic [3:0] operand;
    logic       out_we;
    logic [7:0] ir;
    logic       halted;
    state_t     fsm_state;

    int vec  = 0;
    int miss = 0;

    // Per-cycle capture of one cp transaction, index = cycles after the cp rise.
    logic [7:0] cap_acc_we, cap_out_we, cap_progC, cap_halted;
    logic [7:0] cap_ir      [8];
    logic [1:0] cap_acc_op  [8];
    logic [3:0] cap_operand [8];
    logic [3:0] cap_progP   [8];

    instr_fetch_decode dut (
        .clk       (clk),
        .rst       (rst),
        .cp        (cp),
        .pc_addr   (pc_addr),
        .prog_we   (prog_we),
        .prog_addr (prog_addr),
        .prog_data (prog_data),
        .progC     (progC),
        .progP     (progP),
        .acc_we    (acc_we),
        .acc_op    (acc_op),
        .operand   (operand),
        .out_we    (out_we),
        .ir        (ir),
        .halted    (halted),
        .fsm_state (fsm_state)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic write_mem(input logic [3:0] a, input logic [7:0] d);
        @(posedge clk); #1;
        prog_we = 1'b1; prog_addr = a; prog_data = d;
        @(posedge clk); #1;
        prog_we = 1'b0;
    endtask

    task automatic pulse_rst();
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    // Raise cp for 8 clks and record outputs each cycle; optional write lands in the FETCH cycle.
    task automatic run_cp(input logic [3:0] a, input logic wr, input logic [3:0] wa,
                          input logic [7:0] wd);
        @(posedge clk); #1;
        pc_addr = a;
        cp = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            cap_acc_we[c]  = acc_we;
            cap_out_we[c]  = out_we;
            cap_progC[c]   = progC;
            cap_halted[c]  = halted;
            cap_ir[c]      = ir;
            cap_acc_op[c]  = acc_op;
            cap_operand[c] = operand;
            cap_progP[c]   = progP;
            @(posedge clk); #1;
            if (c == 0 && wr) begin
                prog_we = 1'b1; prog_addr = wa; prog_data = wd;
            end else begin
                prog_we = 1'b0;
            end
        end
        cp = 1'b0;
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        vec++; if (fsm_state !== IDLE) begin miss++; $display("FAIL reset_state: got %0d want %0d", fsm_state, IDLE); end
        vec++; if (ir !== 8'h00) begin miss++; $display("FAIL reset_ir: got %h want 00", ir); end
        vec++; if ({progC, acc_we, out_we, halted} !== 4'b0000) begin miss++; $display("FAIL reset_pulses: got %b want 0000", {progC, acc_we, out_we, halted}); end
        vec++; if ({progP, operand, acc_op} !== 10'h0) begin miss++; $display("FAIL reset_regs: got %h want 000", {progP, operand, acc_op}); end
    endtask

    task automatic test_lda();
        write_mem(4'd0, 8'h13);
        run_cp(4'd0, 1'b0, 4'd0, 8'h00);
        vec++; if (cap_ir[1] !== 8'h00) begin miss++; $display("FAIL lda_ir_early: got %h want 00", cap_ir[1]); end
        vec++; if (cap_ir[2] !== 8'h13) begin miss++; $display("FAIL lda_ir: got %h want 13", cap_ir[2]); end
        vec++; if (cap_acc_we !== 8'b0000_1000) begin miss++; $display("FAIL lda_acc_we: got %b want 00001000", cap_acc_we); end
        vec++; if (cap_acc_op[3] !== 2'b00) begin miss++; $display("FAIL lda_acc_op: got %b want 00", cap_acc_op[3]); end
        vec++; if (cap_operand[3] !== 4'h3) begin miss++; $display("FAIL lda_operand: got %h want 3", cap_operand[3]); end
        vec++; if ((cap_out_we | cap_progC) !== 8'h00) begin miss++; $display("FAIL lda_other: got %b want 00000000", cap_out_we | cap_progC); end
    endtask

    task automatic test_jmp();
        write_mem(4'd2, 8'h5A);
        run_cp(4'd2, 1'b0, 4'd0, 8'h00);
        vec++; if (cap_progC !== 8'b0000_1000) begin miss++; $display("FAIL jmp_progC: got %b want 00001000", cap_progC); end
        vec++; if (cap_progP[3] !== 4'hA) begin miss++; $display("FAIL jmp_progP: got %h want a", cap_progP[3]); end
        vec++; if ((cap_acc_we | cap_out_we) !== 8'h00) begin miss++; $display("FAIL jmp_other: got %b want 00000000", cap_acc_we | cap_out_we); end
    endtask

    task automatic test_sub_out_nop();
        write_mem(4'd3, 8'h37);
        write_mem(4'd5, 8'h4C);
        write_mem(4'd7, 8'h9B);
        run_cp(4'd3, 1'b0, 4'd0, 8'h00);
        vec++; if (cap_acc_we !== 8'b0000_1000) begin miss++; $display("FAIL sub_acc_we: got %b want 00001000", cap_acc_we); end
        vec++; if ({cap_acc_op[3], cap_operand[3]} !== 6'b10_0111) begin miss++; $display("FAIL sub_ctrl: got %b want 100111", {cap_acc_op[3], cap_operand[3]}); end
        run_cp(4'd5, 1'b0, 4'd0, 8'h00);
        vec++; if (cap_out_we !== 8'b0000_1000) begin miss++; $display("FAIL out_we: got %b want 00001000", cap_out_we); end
        vec++; if ((cap_acc_we | cap_progC) !== 8'h00) begin miss++; $display("FAIL out_other: got %b want 00000000", cap_acc_we | cap_progC); end
        vec++; if (cap_operand[3] !== 4'hC) begin miss++; $display("FAIL out_operand: got %h want c", cap_operand[3]); end
        run_cp(4'd7, 1'b0, 4'd0, 8'h00);
        vec++; if (cap_ir[2] !== 8'h9B) begin miss++; $display("FAIL nop9_ir: got %h want 9b", cap_ir[2]); end
        vec++; if ((cap_acc_we | cap_out_we | cap_progC) !== 8'h00) begin miss++; $display("FAIL nop9_pulses: got %b want 00000000", cap_acc_we | cap_out_we | cap_progC); end
    endtask

    task automatic test_read_before_write();
        run_cp(4'd4, 1'b1, 4'd4, 8'h24);
        vec++; if (cap_ir[2] !== 8'h00) begin miss++; $display("FAIL rbw_old_ir: got %h want 00", cap_ir[2]); end
        vec++; if ((cap_acc_we | cap_out_we | cap_progC) !== 8'h00) begin miss++; $display("FAIL rbw_no_pulse: got %b want 00000000", cap_acc_we | cap_out_we | cap_progC); end
        run_cp(4'd4, 1'b0, 4'd0, 8'h00);
        vec++; if (cap_ir[2] !== 8'h24) begin miss++; $display("FAIL rbw_new_ir: got %h want 24", cap_ir[2]); end
        vec++; if (cap_acc_we !== 8'b0000_1000) begin miss++; $display("FAIL rbw_add_we: got %b want 00001000", cap_acc_we); end
        vec++; if ({cap_acc_op[3], cap_operand[3]} !== 6'b01_0100) begin miss++; $display("FAIL rbw_add_ctrl: got %b want 010100", {cap_acc_op[3], cap_operand[3]}); end
    endtask

    task automatic test_reset_mid();
        logic seen;
        write_mem(4'd6, 8'h40);
        @(posedge clk); #1;
        pc_addr = 4'd6;
        cp = 1'b1;
        repeat (3) @(negedge clk);
        vec++; if (fsm_state !== DECODE) begin miss++; $display("FAIL mid_in_decode: got %0d want %0d", fsm_state, DECODE); end
        vec++; if (ir !== 8'h40) begin miss++; $display("FAIL mid_ir_before: got %h want 40", ir); end
        rst = 1'b1;
        cp = 1'b0;
        #1;
        vec++; if (fsm_state !== IDLE) begin miss++; $display("FAIL mid_state: got %0d want %0d", fsm_state, IDLE); end
        vec++; if ({ir, operand} !== 12'h000) begin miss++; $display("FAIL mid_ir_operand: got %h want 000", {ir, operand}); end
        seen = out_we;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            if (c == 1) rst = 1'b0;
            @(negedge clk);
            seen = seen | out_we | acc_we | progC;
        end
        vec++; if (seen !== 1'b0) begin miss++; $display("FAIL mid_pulse_dropped: got %b want 0", seen); end
    endtask

    task automatic test_halt();
        write_mem(4'd1, 8'hF0);
        run_cp(4'd1, 1'b0, 4'd0, 8'h00);
        vec++; if ((cap_acc_we | cap_out_we | cap_progC) !== 8'h00) begin miss++; $display("FAIL hlt_no_pulse: got %b want 00000000", cap_acc_we | cap_out_we | cap_progC); end
`ifdef IFD_HALT_EN
        vec++; if (cap_halted !== 8'b1111_0000) begin miss++; $display("FAIL hlt_halted: got %b want 11110000", cap_halted); end
        for (int k = 0; k < 3; k++) begin
            run_cp(4'd0, 1'b0, 4'd0, 8'h00);
            vec++; if ((cap_acc_we | cap_out_we | cap_progC) !== 8'h00) begin miss++; $display("FAIL hlt_ignore_cp%0d: got %b want 00000000", k, cap_acc_we | cap_out_we | cap_progC); end
            vec++; if (cap_halted !== 8'hFF) begin miss++; $display("FAIL hlt_stays%0d: got %b want 11111111", k, cap_halted); end
        end
        // Program writes are still accepted while halted.
        write_mem(4'd8, 8'h2E);
`else
        vec++; if (cap_halted !== 8'h00) begin miss++; $display("FAIL nohlt_halted: got %b want 00000000", cap_halted); end
        for (int k = 0; k < 3; k++) begin
            run_cp(4'd0, 1'b0, 4'd0, 8'h00);
            vec++; if (cap_acc_we !== 8'b0000_1000) begin miss++; $display("FAIL nohlt_lda%0d: got %b want 00001000", k, cap_acc_we); end
            vec++; if (cap_halted !== 8'h00) begin miss++; $display("FAIL nohlt_stays%0d: got %b want 00000000", k, cap_halted); end
        end
        write_mem(4'd8, 8'h2E);
`endif
        pulse_rst();
        @(negedge clk);
        vec++; if ({halted, fsm_state} !== {1'b0, IDLE}) begin miss++; $display("FAIL hlt_rst_clear: got %h want %h", {halted, fsm_state}, {1'b0, IDLE}); end
        run_cp(4'd8, 1'b0, 4'd0, 8'h00);
        vec++; if (cap_acc_we !== 8'b0000_1000) begin miss++; $display("FAIL post_rst_add: got %b want 00001000", cap_acc_we); end
        vec++; if ({cap_acc_op[3], cap_operand[3]} !== 6'b01_1110) begin miss++; $display("FAIL post_rst_ctrl: got %b want 011110", {cap_acc_op[3], cap_operand[3]}); end
        run_cp(4'd0, 1'b0, 4'd0, 8'h00);
        vec++; if (cap_ir[2] !== 8'h13) begin miss++; $display("FAIL mem_survives_rst: got %h want 13", cap_ir[2]); end
    endtask

    initial begin
        rst = 1'b1;
        cp = 1'b0;
        pc_addr = 4'd0;
        prog_we = 1'b0;
        prog_addr = 4'd0;
        prog_data = 8'h00;
        repeat (3) @(posedge clk);
        test_reset();
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        test_lda();
        test_jmp();
        test_sub_out_nop();
        test_read_before_write();
        test_reset_mid();
        test_halt();
        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end

endmodule
